// File: rtl/threshold_pkg.sv
// Shared mode encodings and fixed-level fractions for the adaptive thresholder.
// Fixed levels sit at 1/5, 2/5, 3/5 and 4/5 of full scale.
package threshold_pkg;

    typedef enum logic [2:0] {
        MODE_FIX20 = 3'd0,
        MODE_FIX40 = 3'd1,
        MODE_FIX60 = 3'd2,
        MODE_FIX80 = 3'd3,
        MODE_PROG  = 3'd4,
        MODE_MEAN  = 3'd5,
        MODE_RSV6  = 3'd6,
        MODE_RSV7  = 3'd7
    } thresh_mode_e;

    localparam int unsigned LEVEL_DEN = 5;

    // floor(MAX*(k+1)/5) with MAX = 2**pixel_w - 1
    function automatic int unsigned fixed_level(input int unsigned pixel_w, input int unsigned k);
        return (((32'd1 << pixel_w) - 32'd1) * (k + 32'd1)) / LEVEL_DEN;
    endfunction

endpackage

// File: rtl/frame_mean_acc.sv
// Frame pixel counter, running sum and registered mean of the last completed frame.
// The mean register is loaded and the sum cleared on the frame's final accepted pixel.
module frame_mean_acc #(
    parameter int PIXEL_W    = 8,
    parameter int FRAME_LOG2 = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               accept_i,
    input  logic [PIXEL_W-1:0] pixel_i,
    output logic               first_o,
    output logic               last_o,
    output logic [PIXEL_W-1:0] mean_o
);

    localparam int ACC_W = PIXEL_W + FRAME_LOG2;
    localparam logic [FRAME_LOG2-1:0] CNT_ONE   = 1;
    localparam logic [PIXEL_W-1:0]    MEAN_INIT = {1'b1, {(PIXEL_W-1){1'b0}}};

    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
    logic [PIXEL_W-1:0]    mean_q, mean_d;

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == '1);
    assign mean_o  = mean_q;
    assign acc_sum = acc_q + {{FRAME_LOG2{1'b0}}, pixel_i};

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        mean_d = mean_q;
        if (accept_i) begin
            cnt_d = cnt_q + CNT_ONE;
            if (last_o) begin
                acc_d  = '0;
                mean_d = acc_sum[ACC_W-1:FRAME_LOG2];
            end else begin
                acc_d = acc_sum;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            mean_q <= MEAN_INIT;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            mean_q <= mean_d;
        end
    end

endmodule

// File: rtl/adaptive_threshold.sv
// Streaming binariser: pixel_out = pixel > T, with T chosen per frame from fixed levels,
// a programmed value or the previous frame's mean. One output register, latency 1.
module adaptive_threshold
    import threshold_pkg::*;
#(
    parameter int PIXEL_W    = 8,
    parameter int FRAME_LOG2 = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [2:0]         thresh_mux,
    input  logic [PIXEL_W-1:0] thresh_prog,
    output logic               pixel_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               last_out,
    output logic [PIXEL_W-1:0] mean_out
);

    localparam logic [PIXEL_W-1:0] LEVEL_0 = PIXEL_W'(fixed_level(PIXEL_W, 0));
    localparam logic [PIXEL_W-1:0] LEVEL_1 = PIXEL_W'(fixed_level(PIXEL_W, 1));
    localparam logic [PIXEL_W-1:0] LEVEL_2 = PIXEL_W'(fixed_level(PIXEL_W, 2));
    localparam logic [PIXEL_W-1:0] LEVEL_3 = PIXEL_W'(fixed_level(PIXEL_W, 3));

    // Handshake: a pixel transfers when valid_in && ready_out; the output register
    // can take a new pixel when it is empty or is being drained this cycle.
    logic               accept, first_pix, last_pix;
    thresh_mode_e       mode_q, mode_d, mode_eff;
    logic [PIXEL_W-1:0] prog_q, prog_d, prog_eff, thresh;
    logic               valid_q, valid_d, pix_q, pix_d, last_q, last_d;

    assign ready_out = !valid_q || ready_in;
    assign accept    = valid_in && ready_out;
    assign valid_out = valid_q;
    assign pixel_out = pix_q;
    assign last_out  = last_q;

    frame_mean_acc #(
        .PIXEL_W    (PIXEL_W),
        .FRAME_LOG2 (FRAME_LOG2)
    ) u_mean (
        .clk_i    (clk_in),
        .rst_n_i  (rst_n_in),
        .accept_i (accept),
        .pixel_i  (pixel_in),
        .first_o  (first_pix),
        .last_o   (last_pix),
        .mean_o   (mean_out)
    );

    // The first pixel of a frame already uses the live selection; later pixels use the latch.
    always_comb begin
        mode_eff = first_pix ? thresh_mode_e'(thresh_mux) : mode_q;
        prog_eff = first_pix ? thresh_prog : prog_q;
        thresh   = LEVEL_0;
        case (mode_eff)
            MODE_FIX40: thresh = LEVEL_1;
            MODE_FIX60: thresh = LEVEL_2;
            MODE_FIX80: thresh = LEVEL_3;
            MODE_PROG:  thresh = prog_eff;
            MODE_MEAN:  thresh = mean_out;
            default:    thresh = LEVEL_0;
        endcase
    end

    always_comb begin
        mode_d  = mode_q;
        prog_d  = prog_q;
        valid_d = valid_q;
        pix_d   = pix_q;
        last_d  = last_q;
        if (accept) begin
            if (first_pix) begin
                mode_d = thresh_mode_e'(thresh_mux);
                prog_d = thresh_prog;
            end
            valid_d = 1'b1;
            pix_d   = (pixel_in > thresh);
            last_d  = last_pix;
        end else if (ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mode_q  <= MODE_FIX20;
            prog_q  <= '0;
            valid_q <= 1'b0;
            pix_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            prog_q  <= prog_d;
            valid_q <= valid_d;
            pix_q   <= pix_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_adaptive_threshold.sv
// Directed bench for adaptive_threshold (PIXEL_W=8, FRAME_LOG2=2): expected outputs are
// queued at acceptance and checked by an independent output monitor.
module tb_adaptive_threshold;

  localparam int PW = 8;
  localparam int FL = 2;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [PW-1:0] pixel_in;
  logic          valid_in;
  logic          ready_out;
  logic [2:0]    thresh_mux;
  logic [PW-1:0] thresh_prog;
  logic          pixel_out;
  logic          valid_out;
  logic          ready_in;
  logic          last_out;
  logic [PW-1:0] mean_out;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  adaptive_threshold #(.PIXEL_W(PW), .FRAME_LOG2(FL)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .pixel_in    (pixel_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .thresh_mux  (thresh_mux),
    .thresh_prog (thresh_prog),
    .pixel_out   (pixel_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .last_out    (last_out),
    .mean_out    (mean_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one pixel, wait for acceptance, queue its expected {pixel_out,last_out}
  task automatic send(input logic [PW-1:0] p, input logic [2:0] m, input logic [PW-1:0] tp,
                      input logic ep, input logic el);
    int n;
    @(posedge clk_in); #1;
    valid_in    = 1'b1;
    pixel_in    = p;
    thresh_mux  = m;
    thresh_prog = tp;
    n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_out stayed 0 for pixel %0d", p);
    end else begin
      exp_q.push_back({ep, el});
      @(posedge clk_in);
    end
    #1 valid_in = 1'b0;
  endtask

  // monitor: one transfer per negedge where valid_out && ready_in
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pixel %0d last %0d expected none", pixel_out, last_out);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        check("pixel_out", {31'd0, pixel_out}, {31'd0, e[1]});
        check("last_out", {31'd0, last_out}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    rst_n_in    = 1'b0;
    valid_in    = 1'b0;
    pixel_in    = '0;
    thresh_mux  = 3'd0;
    thresh_prog = '0;
    ready_in    = 1'b1;
    #12;
    check("rst_valid_out", {31'd0, valid_out}, 0);
    check("rst_pixel_out", {31'd0, pixel_out}, 0);
    check("rst_last_out", {31'd0, last_out}, 0);
    check("rst_mean_out", {24'd0, mean_out}, 128);
    check("rst_ready_out", {31'd0, ready_out}, 1);
    @(posedge clk_in); #1 rst_n_in = 1'b1;

    // frame A: mode 1 (T=102)
    send(102, 1, 0, 0, 0);
    send(103, 1, 0, 1, 0);
    send(50,  1, 0, 0, 0);
    send(200, 1, 0, 1, 1);
    check("mean_frame_a", {24'd0, mean_out}, 113);

    // frame B: mode 0 (T=51)
    send(10, 0, 0, 0, 0);
    send(20, 0, 0, 0, 0);
    send(30, 0, 0, 0, 0);
    send(40, 0, 0, 0, 1);
    check("mean_frame_b", {24'd0, mean_out}, 25);

    // frame C: mode 5 (T=25), mode input moved mid-frame is ignored
    send(26,  5, 0, 1, 0);
    send(25,  5, 0, 0, 0);
    send(100, 3, 0, 1, 0);
    send(0,   3, 0, 0, 1);
    check("mean_frame_c", {24'd0, mean_out}, 37);

    // frame D: mode 0 held all frame though mux goes to 3
    send(160, 0, 0, 1, 0);
    send(160, 3, 0, 1, 0);
    send(160, 3, 0, 1, 0);
    send(160, 3, 0, 1, 1);
    check("mean_frame_d", {24'd0, mean_out}, 160);

    // frame E: mode 3 (T=204), strict compare at the level
    send(160, 3, 0, 0, 0);
    send(204, 3, 0, 0, 0);
    send(205, 3, 0, 1, 0);
    send(255, 3, 0, 1, 1);
    check("mean_frame_e", {24'd0, mean_out}, 206);

    // frame F: mode 4 prog=0; prog change mid-frame ignored
    send(1, 4, 0,   1, 0);
    send(0, 4, 255, 0, 0);
    send(1, 4, 255, 1, 0);
    send(2, 4, 255, 1, 1);
    check("mean_frame_f", {24'd0, mean_out}, 1);

    // frame G: mode 4 prog=255
    send(255, 4, 255, 0, 0);
    send(254, 4, 255, 0, 0);
    send(0,   4, 255, 0, 0);
    send(128, 4, 255, 0, 1);
    check("mean_frame_g", {24'd0, mean_out}, 159);

    // frame H: mode 6 behaves as mode 0; downstream stall for 3 cycles
    repeat (2) @(posedge clk_in);
    #1 ready_in = 1'b0;
    send(52, 6, 0, 1, 0);
    fork
      send(51, 6, 0, 0, 0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_in);
          check("stall_ready_out", {31'd0, ready_out}, 0);
          check("stall_valid_out", {31'd0, valid_out}, 1);
          check("stall_pixel_out", {31'd0, pixel_out}, 1);
          check("stall_last_out", {31'd0, last_out}, 0);
        end
        @(posedge clk_in); #1 ready_in = 1'b1;
      end
    join
    send(100, 0, 0, 1, 0);
    send(10,  0, 0, 0, 1);
    check("mean_frame_h", {24'd0, mean_out}, 53);

    // frame I: reset after a partial frame
    send(200, 0, 0, 1, 0);
    send(20,  0, 0, 0, 0);
    @(posedge clk_in); #1 ready_in = 1'b0;
    send(30, 0, 0, 0, 0);
    #3 rst_n_in = 1'b0;
    #1;
    check("midrst_valid_out", {31'd0, valid_out}, 0);
    check("midrst_pixel_out", {31'd0, pixel_out}, 0);
    check("midrst_mean_out", {24'd0, mean_out}, 128);
    check("midrst_ready_out", {31'd0, ready_out}, 1);
    exp_q.delete();
    ready_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // fresh frame after reset: last only on the 4th pixel
    send(60, 0, 0, 1, 0);
    send(70, 0, 0, 1, 0);
    send(80, 0, 0, 1, 0);
    send(90, 0, 0, 1, 1);
    check("mean_after_reset", {24'd0, mean_out}, 75);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_in);
    @(negedge clk_in);
    check("outputs_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
